// File: rtl/gcd_stream_pkg.sv
// Shared types for the streaming binary-GCD core: FSM state encoding and
// the width of the common-power-of-two counter.
package gcd_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } gcd_state_t;

  // k counts shared factors of two; for nonzero operands it stays below n.
  function automatic int k_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One reduction step of Stein's binary GCD on the working pair (x, y, k).
// Purely combinational; the caller registers the results.
module gcd_step
  import gcd_stream_pkg::*;
#(
  parameter int N  = 8,
  parameter int KW = k_width(N)
) (
  input  logic [N-1:0]  x,
  input  logic [N-1:0]  y,
  input  logic [KW-1:0] k,
  output logic [N-1:0]  x_nxt,
  output logic [N-1:0]  y_nxt,
  output logic [KW-1:0] k_nxt,
  output logic          done,
  output logic [N-1:0]  res
);

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    k_nxt = k;
    done  = 1'b0;
    // Restore the shared factors of two; the true gcd always fits in N bits.
    res   = x << k;
    if (y == '0) begin
      done = 1'b1;
    end else if (!x[0] && !y[0]) begin
      x_nxt = x >> 1;
      y_nxt = y >> 1;
      k_nxt = k + 1'b1;
    end else if (!x[0]) begin
      x_nxt = x >> 1;
    end else if (!y[0]) begin
      y_nxt = y >> 1;
    end else if (x < y) begin
      y_nxt = y - x;
    end else begin
      x_nxt = y;
      y_nxt = x - y;
    end
  end

endmodule

// File: rtl/gcd_stream.sv
// Streaming unsigned GCD with valid/ready on both sides and a tag per job.
// One Stein reduction per clock; a result can retire while the next job loads.
module gcd_stream
  import gcd_stream_pkg::*;
#(
  parameter int N     = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     c,
  output logic [TAG_W-1:0] out_tag
);

  localparam int KW = k_width(N);

  gcd_state_t       state;
  logic [N-1:0]     x, y;
  logic [KW-1:0]    k;
  logic [TAG_W-1:0] tag;

  logic [N-1:0]     x_nxt, y_nxt, res;
  logic [KW-1:0]    k_nxt;
  logic             step_done;
  logic             accept;
  logic [N-1:0]     x_ld, y_ld;

  gcd_step #(.N(N), .KW(KW)) u_step (
    .x     (x),
    .y     (y),
    .k     (k),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .k_nxt (k_nxt),
    .done  (step_done),
    .res   (res)
  );

  assign in_ready = nrst & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // A zero operand is moved into y so the first step terminates at once.
  assign x_ld = (a == '0) ? b : a;
  assign y_ld = (a == '0) ? '0 : b;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      x         <= '0;
      y         <= '0;
      k         <= '0;
      tag       <= '0;
      c         <= '0;
      out_tag   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            x     <= x_ld;
            y     <= y_ld;
            k     <= '0;
            tag   <= in_tag;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (step_done) begin
            c         <= res;
            out_tag   <= tag;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            x <= x_nxt;
            y <= y_nxt;
            k <= k_nxt;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              x     <= x_ld;
              y     <= y_ld;
              k     <= '0;
              tag   <= in_tag;
              state <= ST_CALC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
